// File: rtl/sub_cmp_pkg.sv
// Shared types for the bit-serial subtractor/comparator.
//   sub_cmp_state_e : controller FSM states (IDLE, RUN, DONE)
//   cmp_result_t    : one-hot magnitude compare result (lt, eq, gt)
package sub_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_cmp_state_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_result_t;

endpackage

// File: rtl/Fullsubtractor.sv
// 1-bit full subtractor cell: computes A - B - Bin.
// Ports:
//   A, B, Bin  in  : minuend bit, subtrahend bit, borrow-in
//   Difference out : difference bit
//   Bout       out : borrow-out
module Fullsubtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Difference,
  output logic Bout
);

  assign Difference = A ^ B ^ Bin;
  assign Bout       = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_sub_compare.sv
// Bit-serial WIDTH-bit subtractor/comparator. Operands are captured on a valid/ready
// request, one shared full-subtractor cell is stepped over the bits LSB first, and the
// difference, final borrow and one-hot compare flags are returned on a valid/ready response.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake; a (minuend), b (subtrahend) sampled on it
//   rsp_valid/rsp_ready : response handshake
//   diff, borrow        : (a - b) mod 2^WIDTH and final borrow-out (1 iff a < b)
//   a_lt_b/a_eq_b/a_gt_b: one-hot compare result, valid with rsp_valid
module serial_sub_compare
  import sub_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             a_gt_b
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sub_cmp_state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, b_sh_q, diff_sh_q;
  logic             borrow_run_q;
  logic             nz_q;
  logic [CntW-1:0]  cnt_q;

  // Result registers: held from the end of one operation until the next one completes.
  logic [WIDTH-1:0] res_diff_q;
  logic             res_borrow_q;
  cmp_result_t      res_cmp_q;

  logic             cell_d, cell_bout;
  logic             last_bit;
  logic [WIDTH-1:0] diff_sh_nxt;
  logic             nz_nxt;
  cmp_result_t      cmp_nxt;

  Fullsubtractor u_cell (
    .A         (a_sh_q[0]),
    .B         (b_sh_q[0]),
    .Bin       (borrow_run_q),
    .Difference(cell_d),
    .Bout      (cell_bout)
  );

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign diff_sh_nxt = {cell_d, {(WIDTH-1){1'b0}}} | (diff_sh_q >> 1);
  assign nz_nxt      = nz_q | cell_d;

  always_comb begin
    cmp_nxt.lt = cell_bout;
    cmp_nxt.eq = ~cell_bout & ~nz_nxt;
    cmp_nxt.gt = ~cell_bout & nz_nxt;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      diff_sh_q    <= '0;
      borrow_run_q <= 1'b0;
      nz_q         <= 1'b0;
      cnt_q        <= '0;
      res_diff_q   <= '0;
      res_borrow_q <= 1'b0;
      res_cmp_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_sh_q       <= a;
            b_sh_q       <= b;
            diff_sh_q    <= '0;
            borrow_run_q <= 1'b0;
            nz_q         <= 1'b0;
            cnt_q        <= '0;
          end
        end
        RUN: begin
          a_sh_q       <= a_sh_q >> 1;
          b_sh_q       <= b_sh_q >> 1;
          diff_sh_q    <= diff_sh_nxt;
          borrow_run_q <= cell_bout;
          nz_q         <= nz_nxt;
          cnt_q        <= cnt_q + CntW'(1);
          if (last_bit) begin
            res_diff_q   <= diff_sh_nxt;
            res_borrow_q <= cell_bout;
            res_cmp_q    <= cmp_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Held low during reset so no request is taken while the block is being cleared.
  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == DONE);
  assign diff      = res_diff_q;
  assign borrow    = res_borrow_q;
  assign a_lt_b    = res_cmp_q.lt;
  assign a_eq_b    = res_cmp_q.eq;
  assign a_gt_b    = res_cmp_q.gt;

endmodule

// File: tb/tb_serial_sub_compare.sv
module tb_serial_sub_compare;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] a, b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         a_lt_b, a_eq_b, a_gt_b;

  int n_checks = 0;
  int n_fail   = 0;

  serial_sub_compare #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .a        (a),
    .b        (b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .diff     (diff),
    .borrow   (borrow),
    .a_lt_b   (a_lt_b),
    .a_eq_b   (a_eq_b),
    .a_gt_b   (a_gt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [7:0] ed, input logic eb,
                              input logic [2:0] ef);
    check({tag, " diff"}, 32'(diff), 32'(ed));
    check({tag, " borrow"}, 32'(borrow), 32'(eb));
    check({tag, " flags"}, 32'({a_lt_b, a_eq_b, a_gt_b}), 32'(ef));
  endtask

  // Wait (bounded) for rsp_valid after the acceptance edge; checks latency == W.
  task automatic wait_rsp(input string tag, input bit inject);
    int lat = 0;
    while (!rsp_valid && lat < 3 * W) begin
      check({tag, " req_ready low in RUN"}, 32'(req_ready), 32'd0);
      if (inject && lat == 2) begin
        req_valid = 1'b1;
        a = 8'hFF;
        b = 8'h00;
      end
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(W));
  endtask

  // One operation starting in IDLE at posedge+1; ends in IDLE at posedge+1.
  // ef is {lt, eq, gt}.
  task automatic run_op(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                        input logic [7:0] ed, input logic eb, input logic [2:0] ef,
                        input int hold, input bit inject);
    req_valid = 1'b1;
    a = ai;
    b = bi;
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    a = ~ai;
    b = ~bi;
    wait_rsp(tag, inject);
    check_result(tag, ed, eb, ef);
    if (hold > 0) begin
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        step();
        check({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        check_result({tag, " hold"}, ed, eb, ef);
      end
      rsp_ready = 1'b1;
    end
    step();
    check({tag, " rsp_valid after hs"}, 32'(rsp_valid), 32'd0);
    check({tag, " req_ready after hs"}, 32'(req_ready), 32'd1);
    if (inject) begin
      // The pending request raised during RUN is taken only now.
      step();
      req_valid = 1'b0;
      wait_rsp({tag, " pending"}, 1'b0);
      check_result({tag, " pending"}, 8'hFF, 1'b0, 3'b001);
      step();
      check({tag, " pending rsp_valid after hs"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    a = '0;
    b = '0;

    // Reset state.
    step();
    step();
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check_result("reset", 8'h00, 1'b0, 3'b000);
    rst = 1'b0;
    #1;
    check("post-reset req_ready", 32'(req_ready), 32'd1);
    step();

    // Directed operations.
    run_op("gt 5A-3C", 8'h5A, 8'h3C, 8'h1E, 1'b0, 3'b001, 0, 1'b0);
    run_op("lt 3C-5A", 8'h3C, 8'h5A, 8'hE2, 1'b1, 3'b100, 0, 1'b0);
    run_op("lt 00-FF", 8'h00, 8'hFF, 8'h01, 1'b1, 3'b100, 0, 1'b0);
    run_op("eq 77-77", 8'h77, 8'h77, 8'h00, 1'b0, 3'b010, 0, 1'b0);
    run_op("backpressure", 8'hC8, 8'h64, 8'h64, 1'b0, 3'b001, 5, 1'b0);
    run_op("ignored req", 8'h01, 8'h02, 8'hFF, 1'b1, 3'b100, 0, 1'b1);

    // Reset in the 4th RUN cycle.
    req_valid = 1'b1;
    a = 8'h12;
    b = 8'h34;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check_result("midrst", 8'h00, 1'b0, 3'b000);
    rst = 1'b0;
    #1;
    check("midrst req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < W + 2; i++) begin
      step();
      check("midrst no rsp", 32'(rsp_valid), 32'd0);
    end
    run_op("after reset 10-01", 8'h10, 8'h01, 8'h0F, 1'b0, 3'b001, 0, 1'b0);

    // Random back-to-back operations against a golden model.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 5 == 0) ? ra : 8'($urandom_range(0, 255));
      run_op("random", ra, rb, 8'(ra - rb), (ra < rb),
             {(ra < rb), (ra == rb), (ra > rb)}, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub_compare.md
# serial_sub_compare

Bit-serial multi-bit subtractor/comparator controller. It captures two WIDTH-bit operands on a valid/ready request and sequences one shared 1-bit full subtractor cell over the operand bits, LSB first, one bit per clock. It returns the difference A−B, the final borrow and the magnitude-compare flags on a valid/ready response. It sits between a requester (testbench or higher-level ALU sequencer) and the single-bit subtract datapath, trading latency for area.

## Interface
- WIDTH, default 8: operand width in bits; legal range ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; a, b are valid while high.
- req_ready  out  1  block can accept a request.
- a  in  WIDTH  minuend, unsigned.
- b  in  WIDTH  subtrahend, unsigned.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- diff  out  WIDTH  (a − b) mod 2^WIDTH.
- borrow  out  1  final borrow-out; 1 iff a < b.
- a_lt_b, a_eq_b, a_gt_b  out  1 each  one-hot compare result, valid with rsp_valid.

## Operation
- Clocking: one clock. Reset is synchronous and active-high.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch a and b into shift registers, clear the running borrow and the nonzero accumulator, clear bit_cnt, go to RUN.
- RUN:
  - Each cycle, feed a_sh[0], b_sh[0] and borrow_reg to the cell.
  - Shift the cell difference into diff_sh from the MSB side: diff_sh <= {d, diff_sh[WIDTH-1:1]}.
  - borrow_reg <= cell borrow-out; nz <= nz | d.
  - Shift a_sh and b_sh right; bit_cnt++.
  - When bit_cnt == WIDTH−1, the same edge goes to DONE.
- DONE:
  - rsp_valid = 1.
  - diff = diff_sh, borrow = borrow_reg.
  - a_lt_b = borrow_reg.
  - a_eq_b = !borrow_reg && !nz.
  - a_gt_b = !borrow_reg && nz.
  - On rsp_ready, go to IDLE.
- req_ready = (state == IDLE). No request is accepted in RUN or DONE. req_valid in those states is ignored and must stay pending at the source.
- Operands are sampled only at the handshake. Later changes on a and b have no effect.
- Outputs:
  - diff, borrow and the compare flags are registered.
  - They hold their last result until the next request completes.
  - They are meaningful only while rsp_valid = 1.

## Timing
- Reset values:
  - state = IDLE.
  - req_ready = 0 while rst is high, 1 in the first cycle after release.
  - rsp_valid = 0; diff = 0; borrow = 0; all compare flags = 0.
- Latency: a request accepted at edge T gives rsp_valid = 1 from edge T+WIDTH. That is exactly WIDTH RUN cycles.
- Throughput: at most one operation per WIDTH+2 cycles (RUN ×WIDTH, DONE ≥1, IDLE ≥1).
- Backpressure: with rsp_ready = 0 the block stays in DONE indefinitely, with all outputs stable.
- rsp handshake at edge T2: rsp_valid = 0 and req_ready = 1 from T2.
- Reset mid-operation (RUN or DONE):
  - The operation is aborted and no response is produced.
  - All state and outputs return to their reset values at the next edge.
- bit_cnt width is $clog2(WIDTH). It never wraps inside an operation.
- Arithmetic is unsigned and modulo 2^WIDTH. No overflow flag.

## Structure
- Shared package `sub_cmp_pkg`: state enum typedef `sub_cmp_state_e` {IDLE, RUN, DONE}, plus the cmp_result struct typedef (lt, eq, gt).
- One sub-module: the team's existing 1-bit `Fullsubtractor` cell (A, B, Bin → Difference, Bout), instantiated once. The controller owns all sequencing and registers.
- Everything else stays in the top module: FSM, counter, shift registers, flag logic.

## Test plan
All scenarios use WIDTH = 8.
- a=0x5A, b=0x3C, rsp_ready=1 → rsp_valid 8 cycles after acceptance; diff=0x1E, borrow=0, a_gt_b=1.
- a=0x3C, b=0x5A → diff=0xE2, borrow=1, a_lt_b=1. Also a=0x00, b=0xFF → diff=0x01, borrow=1, a_lt_b=1.
- a=0x77, b=0x77 → diff=0x00, borrow=0, a_eq_b=1, other flags 0.
- Backpressure and ignored inputs:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid → outputs stable, req_ready=0 throughout.
  - Assert req_valid with new operands during RUN → not accepted, current result unaffected.
- Reset mid-operation: assert rst in the 4th RUN cycle → next cycle state IDLE, all outputs 0, no rsp_valid. A following request a=0x10, b=0x01 returns diff=0x0F.
- Randomised back-to-back requests against a golden model: check diff, borrow and flags, and check that exactly WIDTH cycles elapse from acceptance to rsp_valid.
